// File: rtl/branch_predictor_if.sv
// Lookup and training bus between the pipeline (master) and the branch predictor (slave).
interface branch_predictor_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] lookup_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [DATA_W-1:0] pred_target;
  logic              upd_valid;
  logic [DATA_W-1:0] upd_pc;
  logic              upd_taken;
  logic [DATA_W-1:0] upd_target;
  logic              upd_mispredict;

  modport master (
    output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
    input  pred_hit, pred_taken, pred_target
  );
  modport slave (
    input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispredict,
    output pred_hit, pred_taken, pred_target
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating counters, combinational lookup and
// saturating update/mispredict statistics.
module bp_entry #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 26,
  parameter int CNT_W  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              sel,
  input  logic              upd_taken,
  input  logic [TAG_W-1:0]  upd_tag,
  input  logic [DATA_W-1:0] upd_target,
  output logic              valid,
  output logic [TAG_W-1:0]  tag,
  output logic [DATA_W-1:0] target,
  output logic              msb
);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

  logic [CNT_W-1:0] cnt;
  logic             hit;

  assign hit = valid && (tag == upd_tag);
  assign msb = cnt[CNT_W-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid  <= 1'b0;
      cnt    <= '0;
      tag    <= '0;
      target <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      cnt   <= '0;
    end else if (sel) begin
      if (hit) begin
        if (upd_taken) begin
          if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
          target <= upd_target;
        end else if (cnt != '0) begin
          cnt <= cnt - CNT_W'(1);
        end
      end else if (upd_taken) begin
        // Miss on a taken branch claims the slot, evicting any alias.
        valid  <= 1'b1;
        tag    <= upd_tag;
        target <= upd_target;
        cnt    <= CNT_WEAK;
      end
    end
  end
endmodule

module branch_predictor #(
  parameter int DATA_W  = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  branch_predictor_if.slave bp,
  input  logic              clear,
  output logic [STAT_W-1:0] stat_updates,
  output logic [STAT_W-1:0] stat_mispredicts
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = DATA_W - IDX_W - 2;

  logic [ENTRIES-1:0]             valid_q;
  logic [ENTRIES-1:0]             msb_q;
  logic [ENTRIES-1:0][TAG_W-1:0]  tag_q;
  logic [ENTRIES-1:0][DATA_W-1:0] target_q;

  logic [IDX_W-1:0] upd_idx, look_idx;
  logic [TAG_W-1:0] upd_tag, look_tag;
  logic             look_hit, unused_pc_bits;

  assign upd_idx        = bp.upd_pc[IDX_W+1:2];
  assign upd_tag        = bp.upd_pc[DATA_W-1:IDX_W+2];
  assign look_idx       = bp.lookup_pc[IDX_W+1:2];
  assign look_tag       = bp.lookup_pc[DATA_W-1:IDX_W+2];
  assign unused_pc_bits = ^{bp.upd_pc[1:0]};

  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    bp_entry #(.DATA_W(DATA_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) u_entry (
      .clock      (clock),
      .reset      (reset),
      .clear      (clear),
      .sel        (bp.upd_valid && (upd_idx == IDX_W'(i))),
      .upd_taken  (bp.upd_taken),
      .upd_tag    (upd_tag),
      .upd_target (bp.upd_target),
      .valid      (valid_q[i]),
      .tag        (tag_q[i]),
      .target     (target_q[i]),
      .msb        (msb_q[i])
    );
  end

  // The post-reset PC (all ones) must never be steered by a stale entry.
  assign look_hit       = !(&bp.lookup_pc) && valid_q[look_idx] && (tag_q[look_idx] == look_tag);
  assign bp.pred_hit    = look_hit;
  assign bp.pred_taken  = look_hit && msb_q[look_idx];
  assign bp.pred_target = look_hit ? target_q[look_idx] : '0;

  // Statistics keep counting through clear; only reset zeroes them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else if (bp.upd_valid) begin
      if (~&stat_updates) stat_updates <= stat_updates + STAT_W'(1);
      if (bp.upd_mispredict && ~&stat_mispredicts)
        stat_mispredicts <= stat_mispredicts + STAT_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a default instance plus a STAT_W=4 instance for saturation.
module tb_branch_predictor;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic clear, clear_s;
  logic [31:0] stat_updates, stat_mispredicts;
  logic [3:0]  s_updates, s_mispredicts;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  branch_predictor_if #(.DATA_W(32)) bi ();
  branch_predictor_if #(.DATA_W(32)) bs ();

  branch_predictor #(.DATA_W(32), .ENTRIES(16), .CNT_W(2), .STAT_W(32)) dut (
    .clock(clock), .reset(reset), .bp(bi), .clear(clear),
    .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts)
  );

  branch_predictor #(.DATA_W(32), .ENTRIES(16), .CNT_W(2), .STAT_W(4)) dut_s (
    .clock(clock), .reset(reset), .bp(bs), .clear(clear_s),
    .stat_updates(s_updates), .stat_mispredicts(s_mispredicts)
  );

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic look(input logic [31:0] pc);
    bi.lookup_pc = pc; #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic mp);
    bi.upd_valid = 1'b1; bi.upd_pc = pc; bi.upd_taken = tk;
    bi.upd_target = tgt; bi.upd_mispredict = mp;
    step();
    bi.upd_valid = 1'b0; bi.upd_mispredict = 1'b0;
  endtask

  task automatic test_reset();
    look(32'h40);
    n_cmp++; if (bi.pred_hit !== 1'b0) begin n_err++; $display("FAIL reset_hit got %0b want 0", bi.pred_hit); end
    n_cmp++; if (bi.pred_taken !== 1'b0) begin n_err++; $display("FAIL reset_taken got %0b want 0", bi.pred_taken); end
    n_cmp++; if (bi.pred_target !== 32'h0) begin n_err++; $display("FAIL reset_target got %h want 0", bi.pred_target); end
    look(32'hFFFF_FFFF);
    n_cmp++; if (bi.pred_hit !== 1'b0) begin n_err++; $display("FAIL reset_hit_ones got %0b want 0", bi.pred_hit); end
    n_cmp++; if (stat_updates !== 32'd0) begin n_err++; $display("FAIL reset_stat_upd got %0d want 0", stat_updates); end
    n_cmp++; if (stat_mispredicts !== 32'd0) begin n_err++; $display("FAIL reset_stat_mis got %0d want 0", stat_mispredicts); end
  endtask

  task automatic test_alloc();
    look(32'h40);
    bi.upd_valid = 1'b1; bi.upd_pc = 32'h40; bi.upd_taken = 1'b1; bi.upd_target = 32'h100; #1;
    n_cmp++; if (bi.pred_hit !== 1'b0) begin n_err++; $display("FAIL alloc_same_cycle got %0b want 0", bi.pred_hit); end
    step();
    bi.upd_valid = 1'b0;
    n_cmp++; if (bi.pred_hit !== 1'b1) begin n_err++; $display("FAIL alloc_hit got %0b want 1", bi.pred_hit); end
    n_cmp++; if (bi.pred_taken !== 1'b1) begin n_err++; $display("FAIL alloc_taken got %0b want 1", bi.pred_taken); end
    n_cmp++; if (bi.pred_target !== 32'h100) begin n_err++; $display("FAIL alloc_target got %h want 100", bi.pred_target); end
    n_cmp++; if (stat_updates !== 32'd1) begin n_err++; $display("FAIL alloc_stat got %0d want 1", stat_updates); end
  endtask

  // cnt 2 -> 1 -> 0 -> 0, then one taken -> 1 (still not taken if the floor held)
  task automatic test_decrement();
    upd(32'h40, 1'b0, 32'h999, 1'b1); look(32'h40);
    n_cmp++; if (bi.pred_taken !== 1'b0) begin n_err++; $display("FAIL dec1_taken got %0b want 0", bi.pred_taken); end
    upd(32'h40, 1'b0, 32'h999, 1'b1); look(32'h40);
    n_cmp++; if (bi.pred_hit !== 1'b1) begin n_err++; $display("FAIL dec2_hit got %0b want 1", bi.pred_hit); end
    n_cmp++; if (bi.pred_target !== 32'h100) begin n_err++; $display("FAIL dec2_target got %h want 100", bi.pred_target); end
    upd(32'h40, 1'b0, 32'h999, 1'b1);
    upd(32'h40, 1'b1, 32'h100, 1'b0); look(32'h40);
    n_cmp++; if (bi.pred_taken !== 1'b0) begin n_err++; $display("FAIL dec_floor_taken got %0b want 0", bi.pred_taken); end
    n_cmp++; if (stat_updates !== 32'd5) begin n_err++; $display("FAIL dec_stat_upd got %0d want 5", stat_updates); end
    n_cmp++; if (stat_mispredicts !== 32'd3) begin n_err++; $display("FAIL dec_stat_mis got %0d want 3", stat_mispredicts); end
  endtask

  // cnt 1 + five taken -> 3; NT -> 2 (taken); NT -> 1 (not taken)
  task automatic test_saturate();
    for (int i = 0; i < 4; i++) upd(32'h40, 1'b1, 32'h100, 1'b0);
    upd(32'h40, 1'b1, 32'h104, 1'b0); look(32'h40);
    n_cmp++; if (bi.pred_target !== 32'h104) begin n_err++; $display("FAIL sat_target got %h want 104", bi.pred_target); end
    upd(32'h40, 1'b0, 32'h0, 1'b0); look(32'h40);
    n_cmp++; if (bi.pred_taken !== 1'b1) begin n_err++; $display("FAIL sat_nt1_taken got %0b want 1", bi.pred_taken); end
    upd(32'h40, 1'b0, 32'h0, 1'b0); look(32'h40);
    n_cmp++; if (bi.pred_taken !== 1'b0) begin n_err++; $display("FAIL sat_nt2_taken got %0b want 0", bi.pred_taken); end
    n_cmp++; if (stat_updates !== 32'd12) begin n_err++; $display("FAIL sat_stat_upd got %0d want 12", stat_updates); end
  endtask

  task automatic test_alias();
    upd(32'h80, 1'b1, 32'h200, 1'b0); look(32'h40);
    n_cmp++; if (bi.pred_hit !== 1'b0) begin n_err++; $display("FAIL alias_old_hit got %0b want 0", bi.pred_hit); end
    upd(32'hC0, 1'b0, 32'h300, 1'b0); look(32'h80);
    n_cmp++; if (bi.pred_hit !== 1'b1) begin n_err++; $display("FAIL alias_new_hit got %0b want 1", bi.pred_hit); end
    n_cmp++; if (bi.pred_taken !== 1'b1) begin n_err++; $display("FAIL alias_new_taken got %0b want 1", bi.pred_taken); end
    n_cmp++; if (bi.pred_target !== 32'h200) begin n_err++; $display("FAIL alias_new_target got %h want 200", bi.pred_target); end
    look(32'hC0);
    n_cmp++; if (bi.pred_hit !== 1'b0) begin n_err++; $display("FAIL alias_nt_miss got %0b want 0", bi.pred_hit); end
  endtask

  task automatic test_all_ones();
    upd(32'hFFFF_FFFF, 1'b1, 32'h300, 1'b0); look(32'hFFFF_FFFF);
    n_cmp++; if (bi.pred_hit !== 1'b0) begin n_err++; $display("FAIL ones_hit got %0b want 0", bi.pred_hit); end
    n_cmp++; if (bi.pred_taken !== 1'b0) begin n_err++; $display("FAIL ones_taken got %0b want 0", bi.pred_taken); end
    n_cmp++; if (bi.pred_target !== 32'h0) begin n_err++; $display("FAIL ones_target got %h want 0", bi.pred_target); end
    look(32'hFFFF_FFFC);
    n_cmp++; if (bi.pred_target !== 32'h300) begin n_err++; $display("FAIL ones_alias_target got %h want 300", bi.pred_target); end
  endtask

  task automatic test_mispredict_gating();
    bi.upd_valid = 1'b0; bi.upd_mispredict = 1'b1; step(); bi.upd_mispredict = 1'b0;
    n_cmp++; if (stat_updates !== 32'd15) begin n_err++; $display("FAIL gate_stat_upd got %0d want 15", stat_updates); end
    n_cmp++; if (stat_mispredicts !== 32'd3) begin n_err++; $display("FAIL gate_stat_mis got %0d want 3", stat_mispredicts); end
  endtask

  task automatic test_clear();
    clear = 1'b1; upd(32'h40, 1'b1, 32'h500, 1'b1); clear = 1'b0;
    look(32'h40);
    n_cmp++; if (bi.pred_hit !== 1'b0) begin n_err++; $display("FAIL clr_hit40 got %0b want 0", bi.pred_hit); end
    look(32'h80);
    n_cmp++; if (bi.pred_hit !== 1'b0) begin n_err++; $display("FAIL clr_hit80 got %0b want 0", bi.pred_hit); end
    look(32'hFFFF_FFFC);
    n_cmp++; if (bi.pred_target !== 32'h0) begin n_err++; $display("FAIL clr_target got %h want 0", bi.pred_target); end
    n_cmp++; if (stat_updates !== 32'd16) begin n_err++; $display("FAIL clr_stat_upd got %0d want 16", stat_updates); end
    n_cmp++; if (stat_mispredicts !== 32'd4) begin n_err++; $display("FAIL clr_stat_mis got %0d want 4", stat_mispredicts); end
    upd(32'h80, 1'b1, 32'h600, 1'b0); look(32'h80);
    n_cmp++; if (bi.pred_target !== 32'h600) begin n_err++; $display("FAIL clr_realloc got %h want 600", bi.pred_target); end
  endtask

  task automatic test_async_reset();
    #2 reset = 1'b0; #1;
    n_cmp++; if (bi.pred_hit !== 1'b0) begin n_err++; $display("FAIL areset_hit got %0b want 0", bi.pred_hit); end
    n_cmp++; if (stat_updates !== 32'd0) begin n_err++; $display("FAIL areset_stat got %0d want 0", stat_updates); end
    @(negedge clock); reset = 1'b1; step();
  endtask

  task automatic test_stat_saturate();
    bs.upd_valid = 1'b1; bs.upd_pc = 32'h40; bs.upd_taken = 1'b1;
    bs.upd_target = 32'h100; bs.upd_mispredict = 1'b1;
    for (int i = 0; i < 14; i++) step();
    n_cmp++; if (s_updates !== 4'd14) begin n_err++; $display("FAIL ssat14_upd got %0d want 14", s_updates); end
    for (int i = 0; i < 6; i++) step();
    bs.upd_valid = 1'b0; bs.upd_mispredict = 1'b0;
    n_cmp++; if (s_updates !== 4'd15) begin n_err++; $display("FAIL ssat_upd got %0d want 15", s_updates); end
    n_cmp++; if (s_mispredicts !== 4'd15) begin n_err++; $display("FAIL ssat_mis got %0d want 15", s_mispredicts); end
  endtask

  initial begin
    clear = 1'b0; clear_s = 1'b0;
    bi.lookup_pc = '0; bi.upd_valid = 1'b0; bi.upd_pc = '0; bi.upd_taken = 1'b0;
    bi.upd_target = '0; bi.upd_mispredict = 1'b0;
    bs.lookup_pc = '0; bs.upd_valid = 1'b0; bs.upd_pc = '0; bs.upd_taken = 1'b0;
    bs.upd_target = '0; bs.upd_mispredict = 1'b0;
    #12 reset = 1'b1;
    step();
    test_reset();
    test_alloc();
    test_decrement();
    test_saturate();
    test_alias();
    test_all_ones();
    test_mispredict_gating();
    test_clear();
    test_async_reset();
    test_stat_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage pipeline CPU.
- Direct-mapped branch target buffer, one N-bit saturating counter per entry. Replaces the fixed "predict not taken, flush on resolve" scheme.
- Queried combinationally by IF with the current PC. Trained by the resolved branch outcome from EX/MEM.
- Also keeps saturating update and mispredict statistics counters for the benches.

Parameters:
- DATA_W, 32: PC and target width.
- ENTRIES, 16: table depth. Power of two, at least 2. IDX_W = log2(ENTRIES).
- CNT_W, 2: width of each saturating counter, at least 1.
- STAT_W, 32: width of each statistics counter.

Ports:
- clock, input, 1: single clock; all state changes on the rising edge.
- reset, input, 1: asynchronous, active-low reset.
- lookup_pc, input, DATA_W: IF-stage PC.
- pred_hit, output, 1: lookup_pc hits a valid entry with matching tag.
- pred_taken, output, 1: predict taken.
- pred_target, output, DATA_W: predicted target; 0 when pred_hit=0.
- upd_valid, input, 1: a branch resolved this cycle.
- upd_pc, input, DATA_W: PC of the resolved branch.
- upd_taken, input, 1: actual outcome.
- upd_target, input, DATA_W: actual target when taken.
- upd_mispredict, input, 1: pipeline reports that the earlier prediction was wrong. Qualified by upd_valid.
- clear, input, 1: synchronous invalidate of all entries.
- stat_updates, output, STAT_W: count of accepted updates.
- stat_mispredicts, output, STAT_W: count of mispredicts.

Behaviour:
- Address split:
  - idx = pc[IDX_W+1:2].
  - tag = pc[DATA_W-1:IDX_W+2].
  - pc[1:0] are ignored.
- Per-entry state: valid, tag, target, cnt[CNT_W-1:0].
- Reset (reset=0, asynchronous):
  - All valid bits = 0, all cnt = 0, both stat counters = 0.
  - Outputs therefore read pred_hit=0, pred_taken=0, pred_target=0.
  - Tags and targets are don't-care but must never reach an output while invalid.
- Lookup is combinational, zero latency, from registered state.
  - pred_hit = valid[idx] && tag match.
  - pred_taken = pred_hit && cnt[idx][CNT_W-1].
  - pred_target = pred_hit ? target[idx] : 0.
- lookup_pc = all-ones (the CPU's post-reset PC value) is forced to a miss: all three prediction outputs are 0.
- Update, on the rising edge with upd_valid=1 and clear=0:
  - Hit on upd_pc: upd_taken=1 increments cnt, saturating at 2^CNT_W-1, and writes target=upd_target. upd_taken=0 decrements cnt, saturating at 0; target is unchanged.
  - Miss and upd_taken=1: allocate or overwrite the entry. Set valid=1, tag, target=upd_target, cnt=2^(CNT_W-1) (weakly taken).
  - Miss and upd_taken=0: no table change.
- Read during write: a lookup to the index being updated in the same cycle sees the pre-update contents. New state is visible from the next cycle. No bypass.
- clear=1 on a rising edge:
  - All valid bits = 0 and all cnt = 0.
  - clear takes priority over a simultaneous upd_valid. That update is dropped from the table but is still counted in the statistics.
  - clear does not reset the statistics counters.
- Statistics, on the rising edge with upd_valid=1:
  - stat_updates increments by 1.
  - stat_mispredicts increments by 1 if upd_mispredict=1.
  - Both saturate at all-ones and never wrap.
  - upd_mispredict is ignored when upd_valid=0.
- Tag or index aliasing: a later taken update replaces the earlier entry. The older branch then misses.
- Reset asserted mid-operation: all state clears immediately, regardless of clock.

Test Plan:
1. Reset, then lookup_pc=0x40 and lookup_pc=0xFFFFFFFF -> pred_hit=0, pred_taken=0, pred_target=0, stat_updates=0.
2. Update pc=0x40, taken, target=0x100 -> same-cycle lookup 0x40 still misses; next cycle hit=1, taken=1, target=0x100, cnt=2, stat_updates=1.
3. Two not-taken updates on 0x40 -> cnt goes 1 then 0. hit=1, taken=0, target still 0x100. A third not-taken update keeps cnt=0.
4. Five taken updates on 0x40 -> cnt saturates at 3. One not-taken update -> cnt=2, still predicts taken.
5. Aliasing (ENTRIES=16): valid entry at 0x40, then taken update pc=0x80 target=0x200 -> lookup 0x40 misses, lookup 0x80 hits with target 0x200. A not-taken update on a miss at 0xC0 leaves the table unchanged.
6. Simultaneous clear and taken update with mispredict=1 -> next cycle all lookups miss, stat_updates and stat_mispredicts each +1. With STAT_W=4, 20 mispredicting updates -> both counters hold at 15.
